// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared DLX encodings, instruction field positions and IF/ID state type
package dlx_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [11:0] END_MARKER = 12'h300;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS1_MSB    = 25;
   localparam int RS1_LSB    = 21;
   localparam int RS2_MSB    = 20;
   localparam int RS2_LSB    = 16;
   localparam int MARKER_MSB = 11;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } if_id_state_t;

   // Stores read rs2 as their data source, R-type reads it as an operand.
   function automatic logic usesRs2(input logic [5:0] opcode);
      return (opcode == OP_RTYPE) || ((opcode >= OP_SB) && (opcode <= OP_SW));
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard between ID/EX load and the IF/ID instruction
module load_use_detect
   import dlx_pkg::*;
(
   input  logic [31:0] instructionId,
   input  logic        validId,
   input  logic        memReadEx,
   input  logic [4:0]  rdEx,
   output logic        hazard
);

   logic [5:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       unusedLowBits;

   assign opcode = instructionId[OPCODE_MSB:OPCODE_LSB];
   assign rs1    = instructionId[RS1_MSB:RS1_LSB];
   assign rs2    = instructionId[RS2_MSB:RS2_LSB];
   assign unusedLowBits = ^instructionId[RS2_LSB-1:0];

   // r0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign hazard = validId && memReadEx && (rdEx != 5'd0) &&
                   ((rdEx == rs1) || (usesRs2(opcode) && (rdEx == rs2)));

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID register with flush, load-use stall and end-of-program drain
// Optional feature: IF_ID_LOAD_USE_STALL_EN enables load-use hazard stalling.
module if_id_stage
   import dlx_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instructionIf,
   input  logic [31:0] pcPlus4If,
   input  logic        branchTaken,
   input  logic        jumpTaken,
   input  logic        memReadEx,
   input  logic [4:0]  rdEx,
   output logic [31:0] instructionId,
   output logic [31:0] pcPlus4Id,
   output logic        validId,
   output logic        stall,
   output logic        halt
);

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   if_id_state_t state, stateNext;
   logic [3:0]   drainCnt, drainCntNext;
   logic [31:0]  instrNext;
   logic [31:0]  pcNext;
   logic         validNext;
   logic         haltNext;
   logic         endInId;

`ifdef IF_ID_LOAD_USE_STALL_EN
   logic hazard;

   load_use_detect uDetect (
      .instructionId (instructionId),
      .validId       (validId),
      .memReadEx     (memReadEx),
      .rdEx          (rdEx),
      .hazard        (hazard)
   );

   assign stall = (state == RUN) && hazard;
`else
   logic unusedHazardInputs;

   assign unusedHazardInputs = ^{memReadEx, rdEx};
   assign stall = 1'b0;
`endif

   assign endInId = validId && (instructionId[MARKER_MSB:0] == END_MARKER);

   always_comb begin
      stateNext    = state;
      drainCntNext = drainCnt;
      instrNext    = instructionId;
      pcNext       = pcPlus4Id;
      validNext    = validId;
      haltNext     = halt;
      case (state)
         RUN: begin
            if (!stall) begin
               if (endInId) begin
                  // Nothing behind the marker is allowed into decode.
                  stateNext    = DRAIN;
                  drainCntNext = DRAIN_LOAD;
                  instrNext    = NOP_INSTR;
                  validNext    = 1'b0;
               end else if (branchTaken || jumpTaken) begin
                  instrNext = NOP_INSTR;
                  pcNext    = pcPlus4If;
                  validNext = 1'b0;
               end else begin
                  instrNext = instructionIf;
                  pcNext    = pcPlus4If;
                  validNext = 1'b1;
               end
            end
         end
         DRAIN: begin
            instrNext    = NOP_INSTR;
            validNext    = 1'b0;
            drainCntNext = drainCnt - 4'd1;
            if (drainCnt == 4'd1) begin
               stateNext = HALTED;
               haltNext  = 1'b1;
            end
         end
         HALTED: begin
            instrNext = NOP_INSTR;
            validNext = 1'b0;
            haltNext  = 1'b1;
         end
         default: begin
            stateNext = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         drainCnt      <= 4'd0;
         instructionId <= NOP_INSTR;
         pcPlus4Id     <= 32'd0;
         validId       <= 1'b0;
         halt          <= 1'b0;
      end else begin
         state         <= stateNext;
         drainCnt      <= drainCntNext;
         instructionId <= instrNext;
         pcPlus4Id     <= pcNext;
         validId       <= validNext;
         halt          <= haltNext;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage (honours IF_ID_LOAD_USE_STALL_EN)
module tb_if_id_stage;

`ifdef IF_ID_LOAD_USE_STALL_EN
   localparam logic EN = 1'b1;
`else
   localparam logic EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instructionIf;
   logic [31:0] pcPlus4If;
   logic        branchTaken;
   logic        jumpTaken;
   logic        memReadEx;
   logic [4:0]  rdEx;
   logic [31:0] instructionId;
   logic [31:0] pcPlus4Id;
   logic        validId;
   logic        stall;
   logic        halt;

   int nVec = 0;
   int nBad = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        halt;
      logic        chkPc;
      string       name;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] iIf;
      logic [31:0] pIf;
      logic        br;
      logic        jp;
      logic        mr;
      logic [4:0]  rd;
      logic        eStall;
      logic [31:0] eInstr;
      logic [31:0] ePc;
      logic        eValid;
   } vec_t;

   exp_t sb[$];

   if_id_stage #(.DRAIN_CYCLES(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instructionIf (instructionIf),
      .pcPlus4If     (pcPlus4If),
      .branchTaken   (branchTaken),
      .jumpTaken     (jumpTaken),
      .memReadEx     (memReadEx),
      .rdEx          (rdEx),
      .instructionId (instructionId),
      .pcPlus4Id     (pcPlus4Id),
      .validId       (validId),
      .stall         (stall),
      .halt          (halt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nVec++;
      if (act !== req) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic cyc(input string name, input logic [31:0] iIf, input logic [31:0] pIf,
                      input logic br, input logic jp, input logic mr, input logic [4:0] rd,
                      input logic eStall, input logic [31:0] eI, input logic [31:0] eP,
                      input logic eV, input logic eH, input logic chkPc);
      exp_t e;
      @(negedge clk);
      instructionIf = iIf;
      pcPlus4If     = pIf;
      branchTaken   = br;
      jumpTaken     = jp;
      memReadEx     = mr;
      rdEx          = rd;
      #1;
      chk({name, ".stall"}, {31'd0, stall}, {31'd0, eStall});
      sb.push_back('{instr: eI, pc: eP, valid: eV, halt: eH, chkPc: chkPc, name: name});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         nVec++;
         nBad++;
         $display("FAIL %s.scoreboard: got empty queue, expected one entry", name);
      end else begin
         e = sb.pop_front();
         chk({e.name, ".instr"}, instructionId, e.instr);
         chk({e.name, ".valid"}, {31'd0, validId}, {31'd0, e.valid});
         chk({e.name, ".halt"}, {31'd0, halt}, {31'd0, e.halt});
         if (e.chkPc) chk({e.name, ".pc"}, pcPlus4Id, e.pc);
      end
   endtask

   task automatic chkReset(input string name);
      chk({name, ".instr"}, instructionId, 32'h0);
      chk({name, ".pc"}, pcPlus4Id, 32'h0);
      chk({name, ".valid"}, {31'd0, validId}, 32'd0);
      chk({name, ".halt"}, {31'd0, halt}, 32'd0);
      chk({name, ".stall"}, {31'd0, stall}, 32'd0);
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{"plain0", 32'h20010005, 32'h04, 0, 0, 0, 5'd0, 0, 32'h20010005, 32'h04, 1};
      vt[1] = '{"branch", 32'h00221820, 32'h08, 1, 0, 0, 5'd0, 0, 32'h00000000, 32'h08, 0};
      vt[2] = '{"jump",   32'h8C220000, 32'h0C, 0, 1, 0, 5'd0, 0, 32'h00000000, 32'h0C, 0};
      vt[3] = '{"plain1", 32'h00221820, 32'h10, 0, 0, 0, 5'd0, 0, 32'h00221820, 32'h10, 1};
      vt[4] = '{"rd0",    32'hAC230004, 32'h14, 0, 0, 1, 5'd0, 0, 32'hAC230004, 32'h14, 1};
      vt[5] = '{"noDep",  32'h20050001, 32'h18, 0, 0, 1, 5'd5, 0, 32'h20050001, 32'h18, 1};
      vt[6] = '{"ones",   32'hFFFFFFFF, 32'h1C, 0, 0, 0, 5'd5, 0, 32'hFFFFFFFF, 32'h1C, 1};
      vt[7] = '{"flushB", 32'h20010005, 32'h20, 1, 1, 0, 5'd0, 0, 32'h00000000, 32'h20, 0};

      rst_n = 1'b0;
      instructionIf = 32'h0;
      pcPlus4If = 32'h0;
      branchTaken = 1'b0;
      jumpTaken = 1'b0;
      memReadEx = 1'b0;
      rdEx = 5'd0;
      #3;
      chkReset("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i])
         cyc(vt[i].name, vt[i].iIf, vt[i].pIf, vt[i].br, vt[i].jp, vt[i].mr, vt[i].rd,
             vt[i].eStall, vt[i].eInstr, vt[i].ePc, vt[i].eValid, 1'b0, 1'b1);

      // load-use on rs2 of ADD r3,r1,r2: one stall cycle, then the held fetch enters
      cyc("luLoad", 32'h00221820, 32'h24, 0, 0, 0, 5'd0, 0, 32'h00221820, 32'h24, 1, 0, 1);
      cyc("luHit",  32'h8C640008, 32'h28, 0, 0, 1, 5'd2, EN,
          EN ? 32'h00221820 : 32'h8C640008, EN ? 32'h24 : 32'h28, 1, 0, 1);
      cyc("luFree", 32'h8C640008, 32'h28, 0, 0, 0, 5'd0, 0, 32'h8C640008, 32'h28, 1, 0, 1);
      // rdEx of zero never stalls
      cyc("zLoad",  32'h00221820, 32'h2C, 0, 0, 0, 5'd0, 0, 32'h00221820, 32'h2C, 1, 0, 1);
      cyc("zRd",    32'h20010005, 32'h30, 0, 0, 1, 5'd0, 0, 32'h20010005, 32'h30, 1, 0, 1);
      // ADDI does not read rs2, so a match there is not a hazard
      cyc("iRs2",   32'hAC230004, 32'h34, 0, 0, 1, 5'd1, 0, 32'hAC230004, 32'h34, 1, 0, 1);
      // SW reads rs2 (r3)
      cyc("swRs2",  32'h20050001, 32'h38, 0, 0, 1, 5'd3, EN,
          EN ? 32'hAC230004 : 32'h20050001, EN ? 32'h34 : 32'h38, 1, 0, 1);
      cyc("swFree", 32'h00221820, 32'h3C, 0, 0, 0, 5'd0, 0, 32'h00221820, 32'h3C, 1, 0, 1);
      // stall outranks a simultaneous jump
      cyc("sjHit",  32'h11111111, 32'h40, 0, 1, 1, 5'd1, EN,
          EN ? 32'h00221820 : 32'h00000000, EN ? 32'h3C : 32'h40, EN, 0, 1);
      cyc("sjNext", 32'h20010005, 32'h44, 0, 0, 0, 5'd0, 0, 32'h20010005, 32'h44, 1, 0, 1);

      // wrong-path end marker is flushed and never drains
      cyc("wpMark", 32'h00000300, 32'h48, 1, 0, 0, 5'd0, 0, 32'h00000000, 32'h48, 0, 0, 1);
      for (int i = 0; i < 5; i++)
         cyc("wpRun", 32'h20010005 + i, 32'h4C + 4 * i, 0, 0, 0, 5'd0, 0,
             32'h20010005 + i, 32'h4C + 4 * i, 1, 0, 1);

      // drain: marker enters ID, then three bubble cycles and a sticky halt
      cyc("mark", 32'h00000300, 32'h60, 0, 0, 0, 5'd0, 0, 32'h00000300, 32'h60, 1, 0, 1);
      for (int i = 0; i < 7; i++)
         cyc(i >= 3 ? "halted" : "drain", 32'h8C220000, 32'h64, (i == 4), (i == 5), 1, 5'd1, 0,
             32'h00000000, 32'h0, 0, (i >= 3), 0);

      // halted: only reset exits
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chkReset("rstHalt");
      @(negedge clk);
      rst_n = 1'b1;

      // reset asynchronously in the middle of a drain
      cyc("mark2", 32'h00000300, 32'h70, 0, 0, 0, 5'd0, 0, 32'h00000300, 32'h70, 1, 0, 1);
      cyc("drain2", 32'h00221820, 32'h74, 0, 0, 0, 5'd0, 0, 32'h00000000, 32'h0, 0, 0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chkReset("rstDrain");
      @(negedge clk);
      rst_n = 1'b1;
      cyc("afterRst", 32'h20010005, 32'h78, 0, 0, 0, 5'd0, 0, 32'h20010005, 32'h78, 1, 0, 1);
      for (int i = 0; i < 4; i++)
         cyc("runAgain", 32'h00221820, 32'h7C, 0, 0, 0, 5'd0, 0, 32'h00221820, 32'h7C, 1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline boundary for the five-stage DLX core. It sits between the fetch unit and the decode stage. It latches the fetched instruction and PC+4, and it inserts a NOP bubble when a branch or jump is taken. It detects load-use hazards and generates the `stall` that freezes fetch. It also runs the end-of-program drain sequence that raises `halt` once the final instruction has retired.

## Interface
- `DRAIN_CYCLES`, default 3: cycles after the end marker leaves ID before `halt` rises. Legal range is 1..15.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instructionIf` in 32: instruction from fetch.
- `pcPlus4If` in 32: PC+4 from fetch.
- `branchTaken` in 1: taken BEQZ/BNEZ, resolved in ID.
- `jumpTaken` in 1: J/JAL/JR/JALR, resolved in ID.
- `memReadEx` in 1: the instruction in ID/EX is a load.
- `rdEx` in 5: destination register of the ID/EX instruction.
- `instructionId` out 32: registered instruction presented to decode.
- `pcPlus4Id` out 32: registered PC+4 presented to decode and to the fetch branch adder.
- `validId` out 1: `instructionId` is a real instruction, not a bubble.
- `stall` out 1: hold the PC and IF/ID this cycle.
- `halt` out 1: the program has fully drained; this output is sticky.

## Operation
- **Reset values:** `instructionId`=`NOP_INSTR` (32'h0), `pcPlus4Id`=0, `validId`=0, `halt`=0, state=RUN, drain counter=0. `stall` is 0 whenever the block is in reset.
- **Register update in RUN, highest priority first:**
  - `stall`=1: hold all of IF/ID.
  - `branchTaken` or `jumpTaken`: load `NOP_INSTR`, set `validId`=0, load `pcPlus4Id`=`pcPlus4If`.
  - Otherwise: load `instructionIf` and `pcPlus4If`, set `validId`=1.
- **Stall and branch resolution:** stall outranks flush. Decode gates its branch and jump enables with `~stall`, so a branch that waits on a load resolves one cycle later.
- **Hazard detect (combinational):**
  - Fields: `rs1`=[25:21], `rs2`=[20:16], opcode=[31:26].
  - `rs2` is used when the opcode is R-type (6'h00) or a store (6'h28–6'h2B).
  - `stall` = state==RUN & `validId` & `memReadEx` & `rdEx`≠0 & (`rdEx`==`rs1` | (`rs2` used & `rdEx`==`rs2`)).
  - Register 0 never hazards.
- **FSM:**
  - **RUN → DRAIN** when `validId` & `instructionId[11:0]`==`END_MARKER` (12'h300) & ~`stall`. The counter loads `DRAIN_CYCLES`.
  - **DRAIN:** the counter decrements each cycle. When the counter is 1, go to HALTED. IF/ID loads `NOP_INSTR` with `validId`=0 every cycle and ignores all inputs.
  - **HALTED:** `halt`=1 (registered). IF/ID holds NOP. Only `rst_n` exits this state.
- **End marker stalled by a hazard:** it stays in RUN until the stall clears, then enters DRAIN.
- **Wrong-path end marker:** an end marker fetched on a flushed path never reaches ID, so it never triggers the drain.
- **Reset mid-operation:** reset forces every register to its reset value immediately, with no clock needed, regardless of state.

## Timing
- IF→ID latency is 1 cycle.
- `stall` is combinational from registered state plus `memReadEx`/`rdEx`. It is valid before the edge in the same cycle.
- A load-use pair produces exactly one stall cycle, provided ID/EX takes a bubble while `stall` is high.
- A flush replaces exactly one fetched instruction.
- End marker in ID at cycle N, no stall: DRAIN covers N+1..N+`DRAIN_CYCLES`, and `halt` is first high at N+`DRAIN_CYCLES`+1.

## Configuration
- **`IF_ID_LOAD_USE_STALL_EN` defined:** hazard detection is active as described above.
- **Not defined:** `stall` is tied to 0, the `memReadEx`/`rdEx` inputs are ignored, and software must schedule around load delay slots. Flush and drain behaviour is unchanged.

## Structure
- **Shared package `dlx_pkg`:** `NOP_INSTR`, `END_MARKER`, opcode constants (`OP_RTYPE`, `OP_SB`..`OP_SW`), field-position constants, and the `if_id_state_t` enum (RUN/DRAIN/HALTED).
- **Sub-module `load_use_detect`:** combinational; inputs are `instructionId`, `validId`, `memReadEx` and `rdEx`; the output is the raw hazard.
- **Top level:** holds the registers, the FSM and the drain counter.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DRAIN, asynchronously between edges → all outputs return to reset values immediately; FSM returns to RUN.
- **Load-use:** `instructionId` = ADD r3,r1,r2 (32'h00221820), `memReadEx`=1, `rdEx`=2 → `stall`=1 for one cycle and IF/ID holds. Repeat with `rdEx`=0 → `stall`=0.
- **Flush:** `branchTaken`=1 with `instructionIf`=32'h20010005 → next `instructionId`=32'h0, `validId`=0, `pcPlus4Id`=`pcPlus4If`.
- **Stall with branch:** `stall`=1 and `jumpTaken`=1 together → IF/ID holds; no NOP is inserted.
- **Drain:** end marker 32'h00000300 in ID at cycle 10, `DRAIN_CYCLES`=3 → `validId`=0 during cycles 11–13, `halt`=1 from cycle 14 and stays high.
- **Macro off:** compile without `IF_ID_LOAD_USE_STALL_EN`, repeat the load-use stimulus → `stall` stays 0 and the instruction advances.
